// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router ingress controller.
// Imported by the FSM top and the per-port soft-reset timer.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int TIMEOUT_DEF = 30;

endpackage

// File: rtl/router_sr_timer.sv
// Per-port timeout: pulses soft_reset when valid data
// sits unread for TIMEOUT cycles.
module router_sr_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [4:0] LAST = 5'(TIMEOUT - 1);

  logic [4:0] r_cnt;
  logic       r_sr;

  // a read on the timeout edge wins and suppresses the pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_sr  <= 1'b0;
    end else begin
      r_sr <= 1'b0;
      if (!vld || rd) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt <= '0;
        r_sr  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  assign soft_reset = r_sr;

endmodule

// File: rtl/router_pkt_ctrl.sv
// Router ingress FSM: header decode, FIFO select,
// write sequencing, source hold-off and port timeouts.
module router_pkt_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_en,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic [2:0] write_en,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic [2:0] w_sel;
  logic [2:0] w_din_sel;
  logic       w_fsel;
  logic       w_esel;
  logic       w_din_empty;
  logic       w_sr;
  logic       w_load;
  logic       w_hdr_ok;

  assign w_sel       = 3'b001 << r_addr;
  assign w_din_sel   = 3'b001 << data_in;
  assign w_fsel      = |(fifo_full & w_sel);
  assign w_esel      = |(fifo_empty & w_sel);
  assign w_din_empty = |(fifo_empty & w_din_sel);
  assign w_sr        = |(soft_reset & w_sel);
  assign w_hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && w_hdr_ok)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DECODE_ADDRESS:
        if (w_hdr_ok)
          w_next = w_din_empty ? LOAD_FIRST_DATA
                               : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (w_esel) w_next = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        w_next = LOAD_DATA;
      LOAD_DATA:
        if (w_fsel)          w_next = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!w_fsel) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        w_next = DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = LOAD_PARITY;
        else                    w_next = LOAD_DATA;
      LOAD_PARITY:
        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        w_next = w_fsel ? FIFO_FULL_STATE
                        : DECODE_ADDRESS;
      default:
        w_next = DECODE_ADDRESS;
    endcase
    // a port timeout abandons the packet in flight
    if (w_sr && r_state != DECODE_ADDRESS)
      w_next = DECODE_ADDRESS;
  end

  assign detect_add  = (r_state == DECODE_ADDRESS);
  assign lfd_state   = (r_state == LOAD_FIRST_DATA);
  assign ld_state    = (r_state == LOAD_DATA);
  assign laf_state   = (r_state == LOAD_AFTER_FULL);
  assign full_state  = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg = (r_state == CHECK_PARITY_ERROR);
  assign busy        = !(detect_add || ld_state);

  assign w_load   = lfd_state || ld_state || laf_state
                 || (r_state == LOAD_PARITY);
  assign write_en = w_load ? w_sel : 3'b000;
  assign vld_out  = ~fifo_empty;

  for (genvar g = 0; g < 3; g++) begin : g_tmr
    router_sr_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
      .clock      (clock),
      .reset_n    (reset_n),
      .vld        (vld_out[g]),
      .rd         (read_en[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed bench for router_pkt_ctrl: packet flow,
// wait/full handling, timeouts and async reset.
module tb_router_pkt_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_en;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [2:0] write_en;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       busy;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  router_pkt_ctrl #(.TIMEOUT(30)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .read_en       (read_en),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .write_en      (write_en),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pkt_valid = 1'b0;
    data_in = 2'd0;
    fifo_full = 3'b000;
    fifo_empty = 3'b111;
    read_en = 3'b000;
    parity_done = 1'b0;
    low_pkt_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (detect_add !== 1'b1 || busy !== 1'b0 ||
          write_en !== 3'b000 || soft_reset !== 3'b000) begin
        failures++;
        $display("FAIL reset cyc=%0d da=%b busy=%b we=%b sr=%b exp da=1 busy=0 we=000 sr=000",
                 i, detect_add, busy, write_en, soft_reset);
      end
      step();
    end
  endtask

  task automatic test_packet();
    int we_cnt = 0;
    int ri_cnt = 0;
    int ld_cnt = 0;
    pkt_valid = 1'b1;
    data_in = 2'd1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (write_en == 3'b010) we_cnt++;
      if (rst_int_reg) ri_cnt++;
      if (ld_state) begin
        ld_cnt++;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL pkt_ld_busy busy=%b exp=0", busy);
        end
      end
      if (c == 0) begin
        checks++;
        if (lfd_state !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL pkt_lfd lfd=%b busy=%b exp 1 1",
                   lfd_state, busy);
        end
      end
      if (c == 3) pkt_valid = 1'b0;
    end
    checks++;
    if (we_cnt != 5) begin
      failures++;
      $display("FAIL pkt_we_cycles got=%0d exp=5", we_cnt);
    end
    checks++;
    if (ri_cnt != 1 || ld_cnt != 3) begin
      failures++;
      $display("FAIL pkt_ri_ld ri=%0d ld=%0d exp 1 3",
               ri_cnt, ld_cnt);
    end
    checks++;
    if (detect_add !== 1'b1) begin
      failures++;
      $display("FAIL pkt_end da=%b exp=1", detect_add);
    end
  endtask

  task automatic test_wait_empty();
    pkt_valid = 1'b1;
    data_in = 2'd2;
    fifo_empty = 3'b011;
    read_en = 3'b100;
    step();
    pkt_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || write_en !== 3'b000 ||
        detect_add !== 1'b0 || lfd_state !== 1'b0) begin
      failures++;
      $display("FAIL wte busy=%b we=%b da=%b lfd=%b exp 1 000 0 0",
               busy, write_en, detect_add, lfd_state);
    end
    fifo_empty = 3'b111;
    read_en = 3'b000;
    step();
    checks++;
    if (lfd_state !== 1'b1 || write_en !== 3'b100) begin
      failures++;
      $display("FAIL wte_lfd lfd=%b we=%b exp 1 100",
               lfd_state, write_en);
    end
    step();
    step();
    step();
    step();
    checks++;
    if (detect_add !== 1'b1) begin
      failures++;
      $display("FAIL wte_end da=%b exp=1", detect_add);
    end
  endtask

  task automatic test_full();
    pkt_valid = 1'b1;
    data_in = 2'd0;
    step();
    step();
    checks++;
    if (ld_state !== 1'b1 || write_en !== 3'b001) begin
      failures++;
      $display("FAIL full_ld ld=%b we=%b exp 1 001",
               ld_state, write_en);
    end
    fifo_full = 3'b001;
    step();
    step();
    checks++;
    if (full_state !== 1'b1 || write_en !== 3'b000 ||
        busy !== 1'b1) begin
      failures++;
      $display("FAIL full_st full=%b we=%b busy=%b exp 1 000 1",
               full_state, write_en, busy);
    end
    fifo_full = 3'b000;
    step();
    checks++;
    if (laf_state !== 1'b1 || write_en !== 3'b001) begin
      failures++;
      $display("FAIL full_laf laf=%b we=%b exp 1 001",
               laf_state, write_en);
    end
    step();
    checks++;
    if (ld_state !== 1'b1) begin
      failures++;
      $display("FAIL full_reld ld=%b exp=1", ld_state);
    end
    fifo_full = 3'b001;
    step();
    fifo_full = 3'b000;
    step();
    parity_done = 1'b1;
    pkt_valid = 1'b0;
    step();
    parity_done = 1'b0;
    checks++;
    if (detect_add !== 1'b1) begin
      failures++;
      $display("FAIL full_pdone da=%b exp=1", detect_add);
    end
  endtask

  task automatic test_timeout();
    fifo_empty = 3'b110;
    read_en = 3'b000;
    #1;
    checks++;
    if (vld_out !== 3'b001) begin
      failures++;
      $display("FAIL vld_out got=%b exp=001", vld_out);
    end
    for (int i = 1; i <= 31; i++) begin
      step();
      checks++;
      if (soft_reset !== ((i == 30) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL tmo_pulse cyc=%0d got=%b exp=%b", i,
                 soft_reset, (i == 30) ? 3'b001 : 3'b000);
      end
    end
    fifo_empty = 3'b111;
    step();
    fifo_empty = 3'b110;
    for (int i = 1; i <= 29; i++) step();
    read_en = 3'b001;
    step();
    checks++;
    if (soft_reset !== 3'b000) begin
      failures++;
      $display("FAIL tmo_read got=%b exp=000", soft_reset);
    end
    read_en = 3'b000;
    step();
    checks++;
    if (soft_reset !== 3'b000) begin
      failures++;
      $display("FAIL tmo_after got=%b exp=000", soft_reset);
    end
    fifo_empty = 3'b111;
    step();
  endtask

  task automatic test_abandon();
    int bad = 0;
    pkt_valid = 1'b1;
    data_in = 2'd0;
    step();
    step();
    fifo_empty = 3'b110;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ld_state !== 1'b1) bad++;
      if (soft_reset[0] !== (i == 30)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abandon_hold errs=%0d exp=0", bad);
    end
    pkt_valid = 1'b0;
    step();
    checks++;
    if (detect_add !== 1'b1 || write_en !== 3'b000) begin
      failures++;
      $display("FAIL abandon da=%b we=%b exp 1 000",
               detect_add, write_en);
    end
    fifo_empty = 3'b111;
    step();
  endtask

  task automatic test_invalid_and_async();
    int bad = 0;
    pkt_valid = 1'b1;
    data_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      if (detect_add !== 1'b1 || write_en !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL addr3 errs=%0d exp=0", bad);
    end
    data_in = 2'd1;
    step();
    step();
    checks++;
    if (ld_state !== 1'b1 || write_en !== 3'b010) begin
      failures++;
      $display("FAIL async_pre ld=%b we=%b exp 1 010",
               ld_state, write_en);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (detect_add !== 1'b1 || write_en !== 3'b000 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL async_rst da=%b we=%b busy=%b exp 1 000 0",
               detect_add, write_en, busy);
    end
    pkt_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (detect_add !== 1'b1) begin
      failures++;
      $display("FAIL async_post da=%b exp=1", detect_add);
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_wait_empty();
    test_full();
    test_timeout();
    test_abandon();
    test_invalid_and_async();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
